axi_lite_cmd_bridge: RTL and testbench

Responder for the LSU's memory-mapped AXI command registers (address, data, select, strobe, control). It samples the command the core writes there, issues exactly one AXI4-Lite write or read transaction as bus master, and returns the read data and completion status to the core through the `RX_DATA` load path. It sits in the top level, between the LSU command-register outputs and the kit's AXI4-Lite peripheral fabric.

---
 rtl/axi_bridge_pkg.sv | 32 +++
 rtl/axi_lite_cmd_bridge.sv | 230 +++++++++++++++++++++++
 tb/tb_axi_lite_cmd_bridge.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_bridge_pkg.sv
// Shared types and constants for the LSU command-register to AXI4-Lite bridge.
// Command codes, controller states, AXI response codes and the default abort budget.
package axi_bridge_pkg;

  typedef enum logic [1:0] {
    NONE  = 2'b00,
    WRITE = 2'b01,
    READ  = 2'b10,
    RSVD  = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR    = 3'd1,
    WRESP = 3'd2,
    RADDR = 3'd3,
    RDATA = 3'd4
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int unsigned DEFAULT_TIMEOUT = 255;

  // SLVERR and DECERR both carry bit 1; OKAY/EXOKAY do not.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp[1];
  endfunction

endpackage

// File: rtl/axi_lite_cmd_bridge.sv
// Turns one rising edge of the LSU command strobe into a single AXI4-Lite write or
// read, reporting read data and sticky done/error status back to the core.
module axi_lite_cmd_bridge
  import axi_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_axi_addr,
  input  logic [31:0] i_axi_data,
  input  logic        i_axi_sel,
  input  logic [3:0]  i_axi_strobe,
  input  logic [1:0]  i_axi_control,
  output logic [31:0] m_awaddr,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        m_wvalid,
  input  logic        m_wready,
  input  logic [1:0]  m_bresp,
  input  logic        m_bvalid,
  output logic        m_bready,
  output logic [31:0] m_araddr,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rvalid,
  output logic        m_rready,
  output logic [31:0] o_rx_data,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err
);

  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);

  state_e      state_r;
  logic        sel_r;
  logic [15:0] tmo_cnt_r;

  logic        launch_s;
  cmd_e        cmd_s;
  logic        aw_ok_s;
  logic        w_ok_s;
  logic        tmo_hit_s;

  // Launch decode, write-channel progress and timeout detection.
  always_comb begin
    cmd_s     = cmd_e'(i_axi_control);
    launch_s  = 1'b0;
    aw_ok_s   = 1'b0;
    w_ok_s    = 1'b0;
    tmo_hit_s = 1'b0;
    if (state_r == IDLE) begin
      launch_s = i_axi_sel & ~sel_r;
    end else begin
      launch_s = 1'b0;
    end
    // A channel whose valid already dropped has completed its handshake.
    aw_ok_s   = ~m_awvalid | m_awready;
    w_ok_s    = ~m_wvalid | m_wready;
    tmo_hit_s = ((tmo_cnt_r + 16'd1) == TMO_LIMIT);
  end

  // Command controller: strobe edge capture, AXI sequencing, status and timeout.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_r   <= IDLE;
      sel_r     <= 1'b0;
      tmo_cnt_r <= 16'd0;
      m_awaddr  <= 32'd0;
      m_awvalid <= 1'b0;
      m_wdata   <= 32'd0;
      m_wstrb   <= 4'd0;
      m_wvalid  <= 1'b0;
      m_bready  <= 1'b0;
      m_araddr  <= 32'd0;
      m_arvalid <= 1'b0;
      m_rready  <= 1'b0;
      o_rx_data <= 32'd0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_err     <= 1'b0;
    end else begin
      sel_r <= i_axi_sel;
      if (state_r != IDLE) begin
        tmo_cnt_r <= tmo_cnt_r + 16'd1;
      end else begin
        tmo_cnt_r <= tmo_cnt_r;
      end

      case (state_r)
        IDLE: begin
          if (launch_s) begin
            case (cmd_s)
              WRITE: begin
                m_awaddr  <= i_axi_addr;
                m_wdata   <= i_axi_data;
                m_wstrb   <= i_axi_strobe;
                m_awvalid <= 1'b1;
                m_wvalid  <= 1'b1;
                tmo_cnt_r <= 16'd0;
                o_busy    <= 1'b1;
                o_done    <= 1'b0;
                o_err     <= 1'b0;
                state_r   <= WR;
              end
              READ: begin
                m_araddr  <= i_axi_addr;
                m_wdata   <= i_axi_data;
                m_wstrb   <= i_axi_strobe;
                m_arvalid <= 1'b1;
                tmo_cnt_r <= 16'd0;
                o_busy    <= 1'b1;
                o_done    <= 1'b0;
                o_err     <= 1'b0;
                state_r   <= RADDR;
              end
              RSVD: begin
                o_busy <= 1'b0;
                o_done <= 1'b1;
                o_err  <= 1'b1;
              end
              default: begin
                state_r <= IDLE;
              end
            endcase
          end else begin
            state_r <= IDLE;
          end
        end

        WR: begin
          if (tmo_hit_s) begin
            m_awvalid <= 1'b0;
            m_wvalid  <= 1'b0;
            o_busy    <= 1'b0;
            o_done    <= 1'b1;
            o_err     <= 1'b1;
            state_r   <= IDLE;
          end else if (aw_ok_s && w_ok_s) begin
            m_awvalid <= 1'b0;
            m_wvalid  <= 1'b0;
            m_bready  <= 1'b1;
            state_r   <= WRESP;
          end else begin
            if (m_awvalid && m_awready) begin
              m_awvalid <= 1'b0;
            end else begin
              m_awvalid <= m_awvalid;
            end
            if (m_wvalid && m_wready) begin
              m_wvalid <= 1'b0;
            end else begin
              m_wvalid <= m_wvalid;
            end
          end
        end

        WRESP: begin
          // A response landing on the timeout cycle still reports its own status.
          if (m_bvalid) begin
            m_bready <= 1'b0;
            o_err    <= resp_is_err(m_bresp);
            o_done   <= 1'b1;
            o_busy   <= 1'b0;
            state_r  <= IDLE;
          end else if (tmo_hit_s) begin
            m_bready <= 1'b0;
            o_err    <= 1'b1;
            o_done   <= 1'b1;
            o_busy   <= 1'b0;
            state_r  <= IDLE;
          end else begin
            state_r <= WRESP;
          end
        end

        RADDR: begin
          if (tmo_hit_s) begin
            m_arvalid <= 1'b0;
            o_err     <= 1'b1;
            o_done    <= 1'b1;
            o_busy    <= 1'b0;
            state_r   <= IDLE;
          end else if (m_arready) begin
            m_arvalid <= 1'b0;
            m_rready  <= 1'b1;
            state_r   <= RDATA;
          end else begin
            state_r <= RADDR;
          end
        end

        RDATA: begin
          if (m_rvalid) begin
            m_rready  <= 1'b0;
            o_rx_data <= m_rdata;
            o_err     <= resp_is_err(m_rresp);
            o_done    <= 1'b1;
            o_busy    <= 1'b0;
            state_r   <= IDLE;
          end else if (tmo_hit_s) begin
            m_rready <= 1'b0;
            o_err    <= 1'b1;
            o_done   <= 1'b1;
            o_busy   <= 1'b0;
            state_r  <= IDLE;
          end else begin
            state_r <= RDATA;
          end
        end

        default: begin
          m_awvalid <= 1'b0;
          m_wvalid  <= 1'b0;
          m_bready  <= 1'b0;
          m_arvalid <= 1'b0;
          m_rready  <= 1'b0;
          o_busy    <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_cmd_bridge.sv
// Bench for axi_lite_cmd_bridge: directed vector table, reset-in-flight sequence and
// randomized commands, all checked against a cycle-count model of the command protocol.
module tb_axi_lite_cmd_bridge;

  localparam int TMO = 8;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic [31:0] i_axi_addr = 32'd0;
  logic [31:0] i_axi_data = 32'd0;
  logic        i_axi_sel = 1'b0;
  logic [3:0]  i_axi_strobe = 4'd0;
  logic [1:0]  i_axi_control = 2'd0;
  logic [31:0] m_awaddr, m_wdata, m_araddr, o_rx_data;
  logic        m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
  logic [3:0]  m_wstrb;
  logic        o_busy, o_done, o_err;
  logic        m_awready = 1'b0, m_wready = 1'b0, m_bvalid = 1'b0;
  logic        m_arready = 1'b0, m_rvalid = 1'b0;
  logic [1:0]  m_bresp = 2'd0, m_rresp = 2'd0;
  logic [31:0] m_rdata = 32'd0;

  always #5 i_clk = ~i_clk;

  axi_lite_cmd_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_axi_addr(i_axi_addr), .i_axi_data(i_axi_data), .i_axi_sel(i_axi_sel),
    .i_axi_strobe(i_axi_strobe), .i_axi_control(i_axi_control),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .o_rx_data(o_rx_data), .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  // a_d: AW or AR wait cycles, w_d: W wait cycles, e_d: cycles before B or R, resp: B or R response
  typedef struct {
    int          ctrl;
    logic [31:0] addr, data;
    logic [3:0]  strb;
    int          a_d, w_d, e_d;
    logic [1:0]  resp;
    logic [31:0] rdata;
    bit          hold, repulse;
    int          x_busy;
    bit          x_done, x_err;
    logic [31:0] x_rx;
  } vec_t;

  typedef struct {
    int          busy, aw, w, b, ar, r;
    bit          done, err;
    logic [31:0] rx;
  } obs_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  bit          m_done = 1'b0, m_err = 1'b0;
  logic [31:0] m_rx = 32'd0;
  vec_t        tbl[11];

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic vec_t mk(input int ctrl, input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, input int a_d, input int w_d, input int e_d,
                              input logic [1:0] resp, input logic [31:0] rdata, input bit hold,
                              input bit repulse, input int x_busy, input bit x_done,
                              input bit x_err, input logic [31:0] x_rx);
    vec_t v;
    v.ctrl = ctrl; v.addr = addr; v.data = data; v.strb = strb;
    v.a_d = a_d; v.w_d = w_d; v.e_d = e_d; v.resp = resp; v.rdata = rdata;
    v.hold = hold; v.repulse = repulse;
    v.x_busy = x_busy; v.x_done = x_done; v.x_err = x_err; v.x_rx = x_rx;
    return v;
  endfunction

  // Expected outcome from handshake cycle arithmetic: address phase ends at p1, the
  // response arrives at t, and nothing survives past TMO busy cycles.
  function automatic obs_t model(input vec_t v);
    obs_t e;
    int   p1, t, fin;
    e = '{default: 0};
    e.done = m_done; e.err = m_err; e.rx = m_rx;
    if (v.ctrl == 1) begin
      p1 = (v.a_d > v.w_d) ? v.a_d + 1 : v.w_d + 1;
      t = p1 + 1 + v.e_d;
      fin = imin(t, TMO);
      e.busy = fin; e.aw = imin(v.a_d + 1, fin); e.w = imin(v.w_d + 1, fin);
      e.b = (fin > p1) ? fin - p1 : 0;
      e.done = 1'b1; e.err = (t <= TMO) ? v.resp[1] : 1'b1;
    end else if (v.ctrl == 2) begin
      p1 = v.a_d + 1;
      t = p1 + 1 + v.e_d;
      fin = imin(t, TMO);
      e.busy = fin; e.ar = imin(p1, fin);
      e.r = (fin > p1) ? fin - p1 : 0;
      e.done = 1'b1; e.err = (t <= TMO) ? v.resp[1] : 1'b1;
      if (t <= TMO) e.rx = v.rdata;
    end else if (v.ctrl == 3) begin
      e.done = 1'b1; e.err = 1'b1;
    end
    return e;
  endfunction

  task automatic clear_slave();
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0;
    m_arready = 1'b0; m_rvalid = 1'b0;
  endtask

  task automatic run(input vec_t v, input int rst_at, input string tag, output obs_t o);
    int k;
    bit seen_aw, seen_w, seen_ar, ended;
    o = '{default: 0};
    seen_aw = 1'b0; seen_w = 1'b0; seen_ar = 1'b0; ended = 1'b0;
    @(negedge i_clk);
    i_axi_addr = v.addr; i_axi_data = v.data; i_axi_strobe = v.strb;
    i_axi_control = 2'(v.ctrl); i_axi_sel = 1'b1;
    m_bresp = v.resp; m_rresp = v.resp; m_rdata = v.rdata;
    @(posedge i_clk); #1;
    for (k = 1; k <= 40; k++) begin
      if (!o_busy) begin
        ended = 1'b1;
        break;
      end
      o.busy++;
      if (m_awvalid) begin
        o.aw++;
        if (!seen_aw) begin
          check({tag, ".awaddr"}, m_awaddr, v.addr);
          seen_aw = 1'b1;
        end
      end
      if (m_wvalid) begin
        o.w++;
        if (!seen_w) begin
          check({tag, ".wdata"}, m_wdata, v.data);
          check({tag, ".wstrb"}, {28'd0, m_wstrb}, {28'd0, v.strb});
          seen_w = 1'b1;
        end
      end
      if (m_arvalid) begin
        o.ar++;
        if (!seen_ar) begin
          check({tag, ".araddr"}, m_araddr, v.addr);
          seen_ar = 1'b1;
        end
      end
      if (m_bready) o.b++;
      if (m_rready) o.r++;
      i_axi_addr = $urandom; i_axi_data = $urandom; i_axi_strobe = 4'($urandom);
      if (!v.hold) i_axi_sel = v.repulse && (k == 2);
      m_awready = m_awvalid && (o.aw > v.a_d);
      m_wready  = m_wvalid && (o.w > v.w_d);
      m_bvalid  = m_bready && (o.b > v.e_d);
      m_arready = m_arvalid && (o.ar > v.a_d);
      m_rvalid  = m_rready && (o.r > v.e_d);
      if (k == rst_at) begin
        #2 i_rst = 1'b0;
        #1;
        check({tag, ".rst_ctl"},
              {25'd0, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, o_busy, o_done, o_err}, 32'd0);
        check({tag, ".rst_addr"}, m_awaddr | m_araddr | m_wdata | {28'd0, m_wstrb}, 32'd0);
        check({tag, ".rst_rx"}, o_rx_data, 32'd0);
        #2 i_rst = 1'b1;
        ended = 1'b1;
        break;
      end
      @(posedge i_clk); #1;
    end
    if (!ended) check({tag, ".busy_bound"}, 32'(k), 32'd0);
    o.done = o_done; o.err = o_err; o.rx = o_rx_data;
    clear_slave();
    i_axi_sel = v.hold;
    repeat (3) begin
      @(posedge i_clk); #1;
    end
    check({tag, ".no_relaunch"}, {31'd0, o_busy}, 32'd0);
    i_axi_sel = 1'b0;
    @(posedge i_clk); #1;
  endtask

  task automatic cmp_obs(input string tag, input obs_t o, input obs_t e);
    check({tag, ".busy"}, 32'(o.busy), 32'(e.busy));
    check({tag, ".aw"}, 32'(o.aw), 32'(e.aw));
    check({tag, ".w"}, 32'(o.w), 32'(e.w));
    check({tag, ".b"}, 32'(o.b), 32'(e.b));
    check({tag, ".ar"}, 32'(o.ar), 32'(e.ar));
    check({tag, ".r"}, 32'(o.r), 32'(e.r));
    check({tag, ".done"}, {31'd0, o.done}, {31'd0, e.done});
    check({tag, ".err"}, {31'd0, o.err}, {31'd0, e.err});
    check({tag, ".rx"}, o.rx, e.rx);
  endtask

  initial begin
    obs_t  o, e;
    vec_t  v;
    string tag;
    int    r;

    tbl[0]  = mk(1, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 2'b00, 32'h0, 0, 0, 2, 1, 0, 32'h0);
    tbl[1]  = mk(2, 32'h0000_0400, 32'h0, 4'h0, 3, 0, 0, 2'b00, 32'h1234_5678, 0, 0, 5, 1, 0, 32'h1234_5678);
    tbl[2]  = mk(1, 32'h0000_2000, 32'h55AA_00FF, 4'h3, 2, 0, 0, 2'b10, 32'h0, 0, 0, 4, 1, 1, 32'h1234_5678);
    tbl[3]  = mk(2, 32'h0000_0800, 32'h0, 4'h0, 15, 0, 0, 2'b00, 32'hAAAA_AAAA, 0, 0, 8, 1, 1, 32'h1234_5678);
    tbl[4]  = mk(3, 32'h0000_0C00, 32'h1, 4'h1, 0, 0, 0, 2'b00, 32'h0, 0, 0, 0, 1, 1, 32'h1234_5678);
    tbl[5]  = mk(1, 32'h0000_3000, 32'h0F0F_0F0F, 4'h5, 0, 0, 0, 2'b00, 32'h0, 0, 1, 2, 1, 0, 32'h1234_5678);
    tbl[6]  = mk(0, 32'h0000_3400, 32'h2, 4'h2, 0, 0, 0, 2'b11, 32'h0, 0, 0, 0, 1, 0, 32'h1234_5678);
    tbl[7]  = mk(1, 32'h0000_4000, 32'h7777_8888, 4'hC, 1, 1, 5, 2'b01, 32'h0, 0, 0, 8, 1, 0, 32'h1234_5678);
    tbl[8]  = mk(2, 32'h0000_5000, 32'h0, 4'h0, 0, 0, 6, 2'b11, 32'hCAFE_F00D, 0, 0, 8, 1, 1, 32'hCAFE_F00D);
    tbl[9]  = mk(2, 32'h0000_6000, 32'h0, 4'h0, 1, 0, 6, 2'b00, 32'h0BAD_0BAD, 0, 0, 8, 1, 1, 32'hCAFE_F00D);
    tbl[10] = mk(1, 32'h0000_7000, 32'h1357_9BDF, 4'h8, 0, 0, 0, 2'b00, 32'h0, 1, 0, 2, 1, 0, 32'hCAFE_F00D);

    repeat (2) @(negedge i_clk);
    check("reset_ctl", {25'd0, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, o_busy, o_done, o_err}, 32'd0);
    check("reset_data", m_awaddr | m_araddr | m_wdata | o_rx_data | {28'd0, m_wstrb}, 32'd0);
    i_rst = 1'b1;
    repeat (2) @(negedge i_clk);

    for (int i = 0; i < 11; i++) begin
      tag = $sformatf("vec%0d", i);
      e = model(tbl[i]);
      run(tbl[i], 0, tag, o);
      cmp_obs(tag, o, e);
      check({tag, ".tbl_busy"}, 32'(o.busy), 32'(tbl[i].x_busy));
      check({tag, ".tbl_flags"}, {30'd0, o.done, o.err}, {30'd0, tbl[i].x_done, tbl[i].x_err});
      check({tag, ".tbl_rx"}, o.rx, tbl[i].x_rx);
      m_done = e.done; m_err = e.err; m_rx = e.rx;
    end

    // Reset while a read waits in RDATA, then an ordinary read.
    v = mk(2, 32'h0000_8000, 32'h0, 4'h0, 0, 0, 20, 2'b00, 32'hFFFF_0000, 0, 0, 0, 0, 0, 32'h0);
    run(v, 3, "rst_mid", o);
    m_done = 1'b0; m_err = 1'b0; m_rx = 32'd0;
    v = mk(2, 32'h0000_8004, 32'h0, 4'h0, 1, 0, 1, 2'b00, 32'h600D_DA7A, 0, 0, 4, 1, 0, 32'h600D_DA7A);
    e = model(v);
    run(v, 0, "post_rst", o);
    cmp_obs("post_rst", o, e);
    check("post_rst.rx_fixed", o.rx, 32'h600D_DA7A);
    m_done = e.done; m_err = e.err; m_rx = e.rx;

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      v = mk((r == 0) ? 0 : (r == 1) ? 3 : (r < 6) ? 1 : 2, $urandom, $urandom, 4'($urandom),
             $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4), 2'($urandom),
             $urandom, ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0), 0, 0, 0, 32'h0);
      tag = $sformatf("rnd%0d", i);
      e = model(v);
      run(v, 0, tag, o);
      cmp_obs(tag, o, e);
      m_done = e.done; m_err = e.err; m_rx = e.rx;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
